// File: rtl/varlat_rob_interco.sv
// rtl/varlat_rob_interco.sv - variable-latency crossbar interconnect with per-initiator reorder buffers
//
// Purpose: connects NumIn initiators to NumOut banks through a full crossbar
// with round-robin arbitration per bank. Each initiator owns a reorder buffer
// so responses come back in grant order; each bank keeps a FIFO of
// {initiator, slot} tags for its accepted requests.
//
// Ports:
//   clk_i, rst_ni                           clock, asynchronous active-low reset
//   req_i/add_i/we_i/wdata_i/be_i/gnt_o     initiator request channel
//   vld_o/rdata_o                           initiator response channel (registered)
//   req_o/gnt_i/add_o/we_o/wdata_o/be_o     bank request channel
//   rvalid_i/rready_o/rdata_i               bank response channel
module varlat_rob_interco #(
  parameter int unsigned NumIn          = 4,
  parameter int unsigned NumOut         = 8,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned BeWidth        = DataWidth / 8,
  parameter int unsigned AddrMemWidth   = 12,
  parameter int unsigned ByteOffWidth   = $clog2(DataWidth - 1) - 3,
  parameter int unsigned NumOutstanding = 4,
  parameter int unsigned BankFifoDepth  = 2,
  parameter bit          WriteRespOn    = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumIn-1:0]                     req_i,
  input  logic [NumIn-1:0][AddrWidth-1:0]      add_i,
  input  logic [NumIn-1:0]                     we_i,
  input  logic [NumIn-1:0][DataWidth-1:0]      wdata_i,
  input  logic [NumIn-1:0][BeWidth-1:0]        be_i,
  output logic [NumIn-1:0]                     gnt_o,
  output logic [NumIn-1:0]                     vld_o,
  output logic [NumIn-1:0][DataWidth-1:0]      rdata_o,
  output logic [NumOut-1:0]                    req_o,
  input  logic [NumOut-1:0]                    gnt_i,
  output logic [NumOut-1:0][AddrMemWidth-1:0]  add_o,
  output logic [NumOut-1:0]                    we_o,
  output logic [NumOut-1:0][DataWidth-1:0]     wdata_o,
  output logic [NumOut-1:0][BeWidth-1:0]       be_o,
  input  logic [NumOut-1:0]                    rvalid_i,
  output logic [NumOut-1:0]                    rready_o,
  input  logic [NumOut-1:0][DataWidth-1:0]     rdata_i
);

  localparam int unsigned BankLog = $clog2(NumOut);
  localparam int unsigned BankW   = (NumOut > 1) ? BankLog : 1;
  localparam int unsigned IniW    = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int unsigned SlotW   = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam int unsigned CntW    = $clog2(NumOutstanding + 1);
  localparam int unsigned FpW     = (BankFifoDepth > 1) ? $clog2(BankFifoDepth) : 1;
  localparam int unsigned FcW     = $clog2(BankFifoDepth + 1);

  if ((NumIn & (NumIn - 1)) != 0) begin : g_chk_in
    $fatal(1, "NumIn must be a power of 2");
  end
  if ((NumOut & (NumOut - 1)) != 0) begin : g_chk_out
    $fatal(1, "NumOut must be a power of 2");
  end

  // ROB state
  logic [NumIn-1:0][NumOutstanding-1:0]                r_busy, r_done, r_silent;
  logic [NumIn-1:0][NumOutstanding-1:0][DataWidth-1:0] r_data;
  logic [NumIn-1:0][SlotW-1:0]                         r_head, r_tail;
  logic [NumIn-1:0][CntW-1:0]                          r_cnt;
  // bank tag FIFOs and arbiter pointers
  logic [NumOut-1:0][BankFifoDepth-1:0][IniW-1:0]      r_tf_ini;
  logic [NumOut-1:0][BankFifoDepth-1:0][SlotW-1:0]     r_tf_slot;
  logic [NumOut-1:0][FpW-1:0]                          r_tf_wp, r_tf_rp;
  logic [NumOut-1:0][FcW-1:0]                          r_tf_cnt;
  logic [NumOut-1:0][IniW-1:0]                         r_rr;

  logic [NumIn-1:0][BankW-1:0]        w_bank;
  logic [NumIn-1:0][AddrMemWidth-1:0] w_amem;
  logic [NumIn-1:0]                   w_xin_vld, w_rob_nf, w_ret, w_hit;
  logic [NumIn-1:0][DataWidth-1:0]    w_ret_data;
  logic [NumOut-1:0][IniW-1:0]        w_sel;
  logic [NumOut-1:0]                  w_bank_vld, w_tf_nf, w_hs, w_rsp;
  logic                               w_unused;

  assign w_unused = ^add_i;

  for (genvar i = 0; i < NumIn; i++) begin : g_dec
    assign w_bank[i] = (NumOut > 1) ? add_i[i][ByteOffWidth +: BankW] : '0;
    assign w_amem[i] = add_i[i][ByteOffWidth + BankLog +: AddrMemWidth];
  end

  // Response bypass: a bank answering for the head slot retires in the same
  // cycle, giving vld_o one cycle after rvalid_i.
  always_comb begin
    w_hit      = '0;
    w_ret_data = '0;
    for (int i = 0; i < NumIn; i++) begin
      w_ret_data[i] = r_data[i][r_head[i]];
      for (int k = 0; k < NumOut; k++) begin
        if (w_rsp[k] && (r_tf_ini[k][r_tf_rp[k]] == IniW'(i)) &&
            (r_tf_slot[k][r_tf_rp[k]] == r_head[i])) begin
          w_hit[i]      = 1'b1;
          w_ret_data[i] = rdata_i[k];
        end
      end
      w_ret[i]    = r_busy[i][r_head[i]] & (r_done[i][r_head[i]] | w_hit[i]);
      // a full ROB that retires this cycle can accept a new request now
      w_rob_nf[i] = (r_cnt[i] != CntW'(NumOutstanding)) | w_ret[i];
    end
  end

  assign w_xin_vld = req_i & w_rob_nf;
  assign w_rsp     = rvalid_i & rready_o;

  // Per-bank round-robin: first valid initiator at or after r_rr[k].
  always_comb begin
    int idx;
    idx        = 0;
    w_bank_vld = '0;
    w_sel      = '0;
    for (int k = 0; k < NumOut; k++) begin
      for (int off = 0; off < NumIn; off++) begin
        idx = (int'(r_rr[k]) + off) % NumIn;
        if (!w_bank_vld[k] && w_xin_vld[idx] && (w_bank[idx] == BankW'(k))) begin
          w_bank_vld[k] = 1'b1;
          w_sel[k]      = IniW'(idx);
        end
      end
    end
  end

  for (genvar k = 0; k < NumOut; k++) begin : g_bank
    assign w_tf_nf[k]  = (r_tf_cnt[k] != FcW'(BankFifoDepth));
    assign w_hs[k]     = w_bank_vld[k] & gnt_i[k] & w_tf_nf[k];
    assign req_o[k]    = w_bank_vld[k];
    assign add_o[k]    = w_amem[w_sel[k]];
    assign we_o[k]     = we_i[w_sel[k]];
    assign wdata_o[k]  = wdata_i[w_sel[k]];
    assign be_o[k]     = be_i[w_sel[k]];
    assign rready_o[k] = (r_tf_cnt[k] != '0);
  end

  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < NumIn; i++) begin
      gnt_o[i] = w_xin_vld[i] & w_hs[w_bank[i]] & (w_sel[w_bank[i]] == IniW'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy    <= '0;
      r_done    <= '0;
      r_silent  <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_cnt     <= '0;
      r_tf_ini  <= '0;
      r_tf_slot <= '0;
      r_tf_wp   <= '0;
      r_tf_rp   <= '0;
      r_tf_cnt  <= '0;
      r_rr      <= '0;
      vld_o     <= '0;
      rdata_o   <= '0;
    end else begin
      for (int k = 0; k < NumOut; k++) begin
        if (w_rsp[k]) begin
          r_done[r_tf_ini[k][r_tf_rp[k]]][r_tf_slot[k][r_tf_rp[k]]] <= 1'b1;
          r_tf_rp[k] <= (r_tf_rp[k] == FpW'(BankFifoDepth - 1)) ? '0 : r_tf_rp[k] + 1'b1;
        end
        if (w_hs[k]) begin
          r_tf_ini[k][r_tf_wp[k]]  <= w_sel[k];
          r_tf_slot[k][r_tf_wp[k]] <= r_tail[w_sel[k]];
          r_tf_wp[k] <= (r_tf_wp[k] == FpW'(BankFifoDepth - 1)) ? '0 : r_tf_wp[k] + 1'b1;
          r_rr[k]    <= (w_sel[k] == IniW'(NumIn - 1)) ? '0 : w_sel[k] + 1'b1;
        end
        r_tf_cnt[k] <= r_tf_cnt[k] + FcW'(w_hs[k]) - FcW'(w_rsp[k]);
      end
      // retire before alloc: when full, the retiring head is the slot reallocated
      for (int i = 0; i < NumIn; i++) begin
        vld_o[i] <= w_ret[i] & ~r_silent[i][r_head[i]];
        if (w_ret[i]) begin
          if (!r_silent[i][r_head[i]]) rdata_o[i] <= w_ret_data[i];
          r_busy[i][r_head[i]] <= 1'b0;
          r_head[i] <= (r_head[i] == SlotW'(NumOutstanding - 1)) ? '0 : r_head[i] + 1'b1;
        end
        if (gnt_o[i]) begin
          r_busy[i][r_tail[i]]   <= 1'b1;
          r_done[i][r_tail[i]]   <= 1'b0;
          r_silent[i][r_tail[i]] <= we_i[i] & ~WriteRespOn;
          r_tail[i] <= (r_tail[i] == SlotW'(NumOutstanding - 1)) ? '0 : r_tail[i] + 1'b1;
        end
        r_cnt[i] <= r_cnt[i] + CntW'(gnt_o[i]) - CntW'(w_ret[i]);
      end
    end
  end

  // slot payload needs no reset: it is only read once done is set
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NumOut; k++) begin
      if (w_rsp[k]) r_data[r_tf_ini[k][r_tf_rp[k]]][r_tf_slot[k][r_tf_rp[k]]] <= rdata_i[k];
    end
  end

`ifndef SYNTHESIS
  for (genvar k = 0; k < NumOut; k++) begin : g_assert
    a_rvalid_no_tag: assert property (@(posedge clk_i) disable iff (!rst_ni)
      rvalid_i[k] |-> (r_tf_cnt[k] != '0))
      else $error("bank %0d responded with empty tag FIFO", k);
  end
`endif

endmodule

// File: tb/tb_varlat_rob_interco.sv
// tb/tb_varlat_rob_interco.sv - self-checking bench for varlat_rob_interco
module tb_varlat_rob_interco;

  localparam int NI = 4;
  localparam int NO = 8;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic [NI-1:0]         req_i;
  logic [NI-1:0][31:0]   add_i;
  logic [NI-1:0]         we_i;
  logic [NI-1:0][31:0]   wdata_i;
  logic [NI-1:0][3:0]    be_i;
  logic [NI-1:0]         gnt_o;
  logic [NI-1:0]         vld_o;
  logic [NI-1:0][31:0]   rdata_o;
  logic [NO-1:0]         req_o;
  logic [NO-1:0]         gnt_i;
  logic [NO-1:0][11:0]   add_o;
  logic [NO-1:0]         we_o;
  logic [NO-1:0][31:0]   wdata_o;
  logic [NO-1:0][3:0]    be_o;
  logic [NO-1:0]         rvalid_i;
  logic [NO-1:0]         rready_o;
  logic [NO-1:0][31:0]   rdata_i;

  always #5 clk_i = ~clk_i;

  varlat_rob_interco #(.WriteRespOn(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .add_i(add_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .vld_o(vld_o), .rdata_o(rdata_o),
    .req_o(req_o), .gnt_i(gnt_i), .add_o(add_o), .we_o(we_o), .wdata_o(wdata_o),
    .be_o(be_o), .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]       req;
    logic [3:0][2:0]  bank;
    logic [7:0]       gnt;
    logic [3:0]       exp_gnt;
    logic [7:0]       exp_req;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int bank, input int mem);
    return 32'((mem << 5) | (bank << 2));
  endfunction

  task automatic idle;
    req_i = '0; add_i = '0; we_i = '0; wdata_i = '0; be_i = '0;
    gnt_i = '0; rvalid_i = '0; rdata_i = '0;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    rst_ni = 1'b0;
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic rd(input int ini, input int bank);
    req_i[ini] = 1'b1;
    add_i[ini] = mk(bank, ini + 1);
    we_i[ini]  = 1'b0;
    be_i[ini]  = 4'hF;
  endtask

  int pulses;
  logic [31:0] pdata;

  initial begin
    vecs[0] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd3}, 8'hFF, 4'b0001, 8'h08};
    vecs[1] = '{4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 8'hFF, 4'b1111, 8'h0F};
    vecs[2] = '{4'b1111, {3'd5, 3'd5, 3'd5, 3'd5}, 8'hFF, 4'b0001, 8'h20};
    vecs[3] = '{4'b1110, {3'd5, 3'd5, 3'd5, 3'd5}, 8'hFF, 4'b0010, 8'h20};
    vecs[4] = '{4'b1010, {3'd7, 3'd0, 3'd7, 3'd0}, 8'h7F, 4'b0000, 8'h80};
    vecs[5] = '{4'b0000, {3'd1, 3'd2, 3'd3, 3'd4}, 8'hFF, 4'b0000, 8'h00};
    vecs[6] = '{4'b1100, {3'd1, 3'd6, 3'd0, 3'd0}, 8'h40, 4'b0100, 8'h42};
    vecs[7] = '{4'b0110, {3'd0, 3'd4, 3'd4, 3'd0}, 8'h10, 4'b0010, 8'h10};

    // reset state
    do_reset();
    settle();
    chk("reset vld_o", 64'(vld_o), 0);
    chk("reset rready_o", 64'(rready_o), 0);
    chk("reset rdata_o0", 64'(rdata_o[0]), 0);
    chk("reset gnt_o", 64'(gnt_o), 0);
    chk("reset req_o", 64'(req_o), 0);

    // combinational routing/arbitration from reset state
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int i = 0; i < NI; i++) if (vecs[v].req[i]) rd(i, int'(vecs[v].bank[i]));
      gnt_i = vecs[v].gnt;
      settle();
      chk($sformatf("vec%0d gnt_o", v), 64'(gnt_o), 64'(vecs[v].exp_gnt));
      chk($sformatf("vec%0d req_o", v), 64'(req_o), 64'(vecs[v].exp_req));
    end

    // single read, bank 3
    do_reset();
    rd(0, 3); add_i[0] = mk(3, 12'h12); gnt_i = '1;
    settle();
    chk("single gnt_o", 64'(gnt_o), 64'h1);
    chk("single req_o", 64'(req_o), 64'h08);
    chk("single add_o3", 64'(add_o[3]), 64'h12);
    tick(); idle(); rvalid_i[3] = 1'b1; rdata_i[3] = 32'hA5A5;
    settle();
    chk("single rready_o", 64'(rready_o), 64'h08);
    chk("single vld early", 64'(vld_o), 0);
    tick(); idle(); settle();
    chk("single vld_o", 64'(vld_o), 64'h1);
    chk("single rdata_o", 64'(rdata_o[0]), 64'hA5A5);
    chk("single rready after", 64'(rready_o), 0);
    tick(); settle();
    chk("single vld drop", 64'(vld_o), 0);

    // reorder: bank 2 then bank 5, bank 5 answers first
    do_reset();
    rd(1, 2); gnt_i = '1; settle();
    chk("reord gnt0", 64'(gnt_o), 64'b0010);
    tick(); idle(); rd(1, 5); gnt_i = '1; settle();
    chk("reord gnt1", 64'(gnt_o), 64'b0010);
    tick(); idle();
    tick(); rvalid_i[5] = 1'b1; rdata_i[5] = 32'h55; settle();
    chk("reord rready t3", 64'(rready_o), 64'h24);
    tick(); idle(); settle();
    chk("reord hold t4", 64'(vld_o), 0);
    tick();
    tick(); rvalid_i[2] = 1'b1; rdata_i[2] = 32'h22; settle();
    chk("reord hold t6", 64'(vld_o), 0);
    tick(); idle(); settle();
    chk("reord vld t7", 64'(vld_o), 64'b0010);
    chk("reord data t7", 64'(rdata_o[1]), 64'h22);
    tick(); settle();
    chk("reord vld t8", 64'(vld_o), 64'b0010);
    chk("reord data t8", 64'(rdata_o[1]), 64'h55);
    tick(); settle();
    chk("reord vld t9", 64'(vld_o), 0);

    // ROB full
    do_reset();
    for (int b = 0; b < 4; b++) begin
      if (b > 0) tick();
      idle(); rd(0, b); gnt_i = '1; settle();
      chk($sformatf("full gnt%0d", b), 64'(gnt_o), 64'b0001);
    end
    tick(); idle(); rd(0, 4); gnt_i = '1; settle();
    chk("full stall gnt", 64'(gnt_o), 0);
    chk("full stall req_o", 64'(req_o), 0);
    tick(); rvalid_i[0] = 1'b1; rdata_i[0] = 32'h10; settle();
    chk("full release gnt", 64'(gnt_o), 64'b0001);
    chk("full release req_o", 64'(req_o), 64'h10);
    tick(); idle(); rd(0, 5); gnt_i = '1; settle();
    chk("full vld", 64'(vld_o), 64'b0001);
    chk("full data", 64'(rdata_o[0]), 64'h10);
    chk("full again gnt", 64'(gnt_o), 0);

    // tag FIFO full on bank 0, round-robin across frees
    do_reset();
    for (int i = 0; i < NI; i++) rd(i, 0);
    gnt_i = '1; settle();
    chk("tf gnt c0", 64'(gnt_o), 64'b0001);
    tick(); settle();
    chk("tf gnt c1", 64'(gnt_o), 64'b0010);
    tick(); req_i[1] = 1'b0; settle();
    chk("tf gnt c2", 64'(gnt_o), 0);
    chk("tf req_o c2", 64'(req_o), 64'h01);
    tick(); rvalid_i[0] = 1'b1; rdata_i[0] = 32'hA0; settle();
    chk("tf gnt c3", 64'(gnt_o), 0);
    tick(); rvalid_i[0] = 1'b0; settle();
    chk("tf gnt c4", 64'(gnt_o), 64'b0100);
    chk("tf vld c4", 64'(vld_o), 64'b0001);
    chk("tf data c4", 64'(rdata_o[0]), 64'hA0);
    tick(); req_i[2] = 1'b0; settle();
    chk("tf gnt c5", 64'(gnt_o), 0);
    tick(); rvalid_i[0] = 1'b1; rdata_i[0] = 32'hA1; settle();
    tick(); rvalid_i[0] = 1'b0; settle();
    chk("tf gnt c7", 64'(gnt_o), 64'b1000);
    chk("tf vld c7", 64'(vld_o), 64'b0010);
    chk("tf data c7", 64'(rdata_o[1]), 64'hA1);

    // silent write then read on bank 1
    do_reset();
    req_i[2] = 1'b1; add_i[2] = mk(1, 3); we_i[2] = 1'b1; wdata_i[2] = 32'h99;
    be_i[2] = 4'hF; gnt_i = '1; settle();
    chk("ws gnt write", 64'(gnt_o), 64'b0100);
    chk("ws we_o", 64'(we_o[1]), 64'h1);
    chk("ws wdata_o", 64'(wdata_o[1]), 64'h99);
    tick(); idle(); rd(2, 1); gnt_i = '1; settle();
    chk("ws gnt read", 64'(gnt_o), 64'b0100);
    pulses = 0; pdata = '0;
    tick(); idle(); rvalid_i[1] = 1'b1; rdata_i[1] = 32'h0; settle();
    tick(); rvalid_i[1] = 1'b1; rdata_i[1] = 32'h77; settle();
    chk("ws no write pulse", 64'(vld_o[2]), 0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin tick(); settle(); end
      else begin tick(); idle(); settle(); end
      if (vld_o[2]) begin pulses++; pdata = rdata_o[2]; end
    end
    chk("ws pulse count", 64'(pulses), 64'd1);
    chk("ws read data", 64'(pdata), 64'h77);

    // reset with three outstanding
    do_reset();
    for (int b = 0; b < 3; b++) begin
      if (b > 0) tick();
      idle(); rd(3, b); gnt_i = '1; settle();
    end
    tick(); idle(); rvalid_i[0] = 1'b1; rdata_i[0] = 32'h33; settle();
    chk("rst rready pre", 64'(rready_o), 64'h07);
    tick(); idle(); settle();
    chk("rst vld pre", 64'(vld_o), 64'b1000);
    rst_ni = 1'b0;
    #1;
    chk("rst vld async", 64'(vld_o), 0);
    chk("rst rready async", 64'(rready_o), 0);
    chk("rst rdata async", 64'(rdata_o[3]), 0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    rd(3, 6); gnt_i = '1; settle();
    chk("rst fresh gnt", 64'(gnt_o), 64'b1000);
    chk("rst fresh rready", 64'(rready_o), 0);
    tick(); idle(); rvalid_i[6] = 1'b1; rdata_i[6] = 32'hBEEF; settle();
    chk("rst no stale", 64'(vld_o), 0);
    tick(); idle(); settle();
    chk("rst fresh vld", 64'(vld_o), 64'b1000);
    chk("rst fresh data", 64'(rdata_o[3]), 64'hBEEF);
    tick(); settle();
    chk("rst fresh drop", 64'(vld_o), 0);
    chk("rst fresh rready", 64'(rready_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/varlat_rob_interco.md
# varlat_rob_interco

Variable-latency TCDM-style interconnect connecting `NumIn` initiators to `NumOut` memory banks through a full crossbar (LIC topology).
- Each initiator gets a reorder buffer (ROB) of `NumOutstanding` slots. It may keep several requests in flight to different banks, and responses return in issue order even when banks answer out of order.
- Each bank keeps an in-order tag FIFO. Because ROB slots are preallocated, bank responses are never back-pressured by initiator ordering.
- The block sits between core/DMA request ports and the memory-island banks.

## Interface
Parameters:
- `NumIn`, 4: initiator ports, power of 2.
- `NumOut`, 8: banks, power of 2.
- `AddrWidth`, 32: initiator address width.
- `DataWidth`, 32: data word width.
- `BeWidth`, `DataWidth/8`: byte-enable width.
- `AddrMemWidth`, 12: word-address bits per bank.
- `ByteOffWidth`, `$clog2(DataWidth-1)-3`: byte-offset bits below the bank index.
- `NumOutstanding`, 4: ROB slots per initiator, ≥1.
- `BankFifoDepth`, 2: tag FIFO depth per bank, ≥1.
- `WriteRespOn`, 1: if 0, write completions retire silently without `vld_o`.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `req_i`, in, `NumIn`: request valid.
- `add_i`, in, `NumIn×AddrWidth`: byte address.
- `we_i`, in, `NumIn`: 1 = store.
- `wdata_i`, in, `NumIn×DataWidth`: write data.
- `be_i`, in, `NumIn×BeWidth`: byte enables.
- `gnt_o`, out, `NumIn`: grant, combinational on req/addr/state.
- `vld_o`, out, `NumIn`: response valid, registered.
- `rdata_o`, out, `NumIn×DataWidth`: response data, registered.
- `req_o`, out, `NumOut`: bank request.
- `gnt_i`, in, `NumOut`: bank grant.
- `add_o`, out, `NumOut×AddrMemWidth`: in-bank word address.
- `we_o`, out, `NumOut`: write enable.
- `wdata_o`, out, `NumOut×DataWidth`: write data.
- `be_o`, out, `NumOut×BeWidth`: byte enables.
- `rvalid_i`, in, `NumOut`: bank response valid. Banks respond to every accepted request, reads and writes.
- `rready_o`, out, `NumOut`: bank response ready.
- `rdata_i`, in, `NumOut×DataWidth`: bank response data.

## Operation
Address decode:
- Bank index is `add_i[ByteOffWidth+:log2(NumOut)]`.
- In-bank address is the next `AddrMemWidth` bits above the bank index.

Request path:
- A `simplex_xbar` carries `{we, be, addr, wdata}` with round-robin arbitration, no spill or fall-through registers.
- The crossbar input valid is `req_i & rob_not_full`.
- `gnt_o[i]` = crossbar ready AND ROB[i] not full.
- The crossbar output valid drives `req_o`. Crossbar ready is `gnt_i & tagfifo_not_full`.
- A bank handshake occurs when `req_o & gnt_i & tagfifo_not_full`. Only then is the request counted as issued to the bank.

ROB allocation:
- On `req_i[i] & gnt_o[i]`, slot `tail[i]` is marked busy with `done=0` and `silent = we_i[i] & ~WriteRespOn`.
- `tail[i]` then increments modulo `NumOutstanding`.
- The slot index travels alongside the crossbar request as a tag.

Bank tag FIFO:
- On a bank handshake, the bank pushes `{ini_idx, slot}` into its tag FIFO.
- `rready_o[k]` = tag FIFO k not empty.
- On `rvalid_i[k] & rready_o[k]`: pop the FIFO, write `rdata_i[k]` into ROB[ini].slot, and set `done=1`.
- Several banks may write different slots of the same ROB in the same cycle. Collision-free by construction.

Retire:
- When `head[i]` is busy and done, clear busy and increment head.
- If not silent, register `vld_o[i]=1` with `rdata_o[i]` = slot data on the next edge. Otherwise `vld_o` stays 0.
- At most one retire per initiator per cycle.

Occupancy counter:
- Per ROB, range 0..`NumOutstanding`.
- Full when count = `NumOutstanding`.
- Simultaneous alloc and retire leaves the count unchanged, so a full ROB retiring grants in the same cycle.
- Head and tail are each `$clog2(NumOutstanding)` bits wide, minimum 1 bit. They wrap at `NumOutstanding` also for non-power-of-2 values.

Constraints:
- `rvalid_i` while tag FIFO k is empty is illegal. It is ignored, and an assertion fires.
- `NumIn` or `NumOut` not a power of 2 triggers an elaboration `$fatal`.

## Timing
Reset:
- All pointers, counters and busy/done flags are 0.
- Both tag-FIFO pointers are 0.
- `vld_o`=0, `rdata_o`=0, `rready_o`=0.
- `gnt_o`/`req_o` follow inputs combinationally.

Latency and throughput:
- Grant to bank request is combinational, same cycle.
- Bank `rvalid_i` in cycle t gives `vld_o` in t+1 if that slot is head, i.e. minimum 1 cycle after the bank response.
- Sustained throughput is one response per initiator per cycle.
- Responses arriving for non-head slots wait. Order is strictly by grant order per initiator.

## Test plan
- **Single read:** reset, initiator 0 reads bank 3, bank grants immediately and responds 1 cycle later with 0xA5A5 -> `vld_o[0]=1` with `rdata_o[0]=0xA5A5` exactly 1 cycle after `rvalid_i[3]`.
- **Reorder:** initiator 1 issues reads to bank 2, then bank 5. Bank 5 responds at t=3 (0x55), bank 2 at t=6 (0x22) -> `vld_o[1]` at t=7 with 0x22, then t=8 with 0x55; `rready_o[5]` high at t=3.
- **ROB full:** `NumOutstanding=4`, banks withhold `rvalid` -> 4 grants, then `gnt_o=0`. One head response releases a grant in the retire cycle (count stays 4).
- **Tag FIFO full:** `BankFifoDepth=2`, 4 initiators hit bank 0 with `rvalid_i` low -> only 2 grants, the rest stalled. Arbitration is round-robin across subsequent frees.
- **Write silent:** `WriteRespOn=0`, sequence write bank 1 then read bank 1 (0x77) -> single `vld_o` carrying 0x77, no pulse for the write.
- **Reset mid-flight:** assert `rst_ni` low with 3 outstanding -> `vld_o`/`rready_o` 0 immediately. After release, a fresh read completes normally with no stale response.
